jam_cost_loader: RTL and testbench

JAM_COST_LOADER -- requirements
Module: jam_cost_loader

---
 rtl/jam_pkg.sv | 12 +
 rtl/jam_rowmin.sv | 37 +++
 rtl/jam_cost_loader.sv | 90 +++++++++
 tb/tb_jam_cost_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared constants and types for the cost-matrix loader and its row-minimum tracker.
package jam_pkg;
  localparam int unsigned N      = 8;
  localparam int unsigned COST_W = 7;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned CNT_W  = 7;

  typedef logic [COST_W-1:0] cost_t;

  typedef enum logic {LOAD, FULL} ld_state_t;
endpackage

// File: rtl/jam_rowmin.sv
// Tracks the minimum of the row being streamed and accumulates row minima into a lower bound.
module jam_rowmin
  import jam_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr,
  input  logic             accept,
  input  logic             row_first,
  input  logic             row_last,
  input  cost_t            data,
  output logic [SUM_W-1:0] lb
);

  cost_t row_min;
  cost_t cur_min_c;

  // The first word of a row restarts the running minimum.
  always_comb begin
    cur_min_c = data;
    if (!row_first && (row_min < data)) cur_min_c = row_min;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      row_min <= '0;
      lb      <= '0;
    end else if (clr) begin
      row_min <= '0;
      lb      <= '0;
    end else if (accept) begin
      row_min <= cur_min_c;
      if (row_last) lb <= lb + SUM_W'(cur_min_c);
    end
  end

endmodule

// File: rtl/jam_cost_loader.sv
// Streams an N x N cost matrix row-major into local storage and serves registered reads.
// Optional row-minimum lower bound (LB port) is built when JAM_COST_ROWMIN_EN is defined.
module jam_cost_loader #(
  parameter int unsigned N      = jam_pkg::N,
  parameter int unsigned COST_W = jam_pkg::COST_W
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      CLR,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [COST_W-1:0]         IN_DATA,
  input  logic [jam_pkg::IDX_W-1:0] W,
  input  logic [jam_pkg::IDX_W-1:0] J,
  output logic [COST_W-1:0]         Cost,
  output logic                      LOADED,
  output logic [jam_pkg::CNT_W-1:0] COUNT
`ifdef JAM_COST_ROWMIN_EN
  ,
  output logic [jam_pkg::SUM_W-1:0] LB
`endif
);
  import jam_pkg::*;

  ld_state_t        state;
  logic [IDX_W-1:0] wr_w;
  logic [IDX_W-1:0] wr_j;
  logic [COST_W-1:0] mem [N][N];
  logic             accept_c;
  logic             row_last_c;

  assign IN_READY   = (state == LOAD) && !CLR;
  assign accept_c   = IN_VALID && IN_READY;
  assign row_last_c = (wr_j == IDX_W'(N - 1));

  // Read port samples memory before this edge's write, so a same-address read returns the old word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= LOAD;
      wr_w   <= '0;
      wr_j   <= '0;
      COUNT  <= '0;
      LOADED <= 1'b0;
      Cost   <= '0;
      for (int w = 0; w < int'(N); w++) begin
        for (int j = 0; j < int'(N); j++) begin
          mem[w][j] <= '0;
        end
      end
    end else begin
      Cost <= mem[W][J];
      if (CLR) begin
        state  <= LOAD;
        wr_w   <= '0;
        wr_j   <= '0;
        COUNT  <= '0;
        LOADED <= 1'b0;
      end else if (accept_c) begin
        mem[wr_w][wr_j] <= IN_DATA;
        COUNT           <= COUNT + CNT_W'(1);
        if (row_last_c) begin
          wr_j <= '0;
          if (wr_w == IDX_W'(N - 1)) begin
            wr_w   <= '0;
            state  <= FULL;
            LOADED <= 1'b1;
          end else begin
            wr_w <= wr_w + IDX_W'(1);
          end
        end else begin
          wr_j <= wr_j + IDX_W'(1);
        end
      end
    end
  end

`ifdef JAM_COST_ROWMIN_EN
  jam_rowmin u_rowmin (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr       (CLR),
    .accept    (accept_c),
    .row_first (wr_j == '0),
    .row_last  (row_last_c),
    .data      (IN_DATA),
    .lb        (LB)
  );
`endif

endmodule

// File: tb/tb_jam_cost_loader.sv
// Self-checking bench for jam_cost_loader: per-cycle model comparison plus directed literal checks.
module tb_jam_cost_loader;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CLR;
  logic       IN_VALID;
  logic       IN_READY;
  logic [6:0] IN_DATA;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       LOADED;
  logic [6:0] COUNT;
`ifdef JAM_COST_ROWMIN_EN
  logic [9:0] LB;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  jam_cost_loader dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CLR      (CLR),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_DATA  (IN_DATA),
    .W        (W),
    .J        (J),
    .Cost     (Cost),
    .LOADED   (LOADED),
    .COUNT    (COUNT)
`ifdef JAM_COST_ROWMIN_EN
    ,
    .LB       (LB)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the matrix is a flat array filled at address = number of words accepted so far.
  int m_mem [64];
  int m_count = 0;
  int m_cost  = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int a = 0; a < 64; a++) m_mem[a] = 0;
      m_count = 0;
      m_cost  = 0;
    end else begin
      m_cost = m_mem[int'(W) * 8 + int'(J)];
      if (CLR) begin
        m_count = 0;
      end else if (IN_VALID && (m_count < 64)) begin
        m_mem[m_count] = int'(IN_DATA);
        m_count++;
      end
    end
  end

  function automatic int model_lb();
    int sum = 0;
    for (int r = 0; r < 8; r++) begin
      int mn = m_mem[r * 8];
      for (int j = 1; j < 8; j++) if (m_mem[r * 8 + j] < mn) mn = m_mem[r * 8 + j];
      sum += mn;
    end
    return sum;
  endfunction

  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      chk("cycle_cost", Cost, m_cost);
      chk("cycle_count", COUNT, m_count);
      chk("cycle_loaded", LOADED, m_count == 64);
      chk("cycle_in_ready", IN_READY, (m_count < 64) && !CLR);
`ifdef JAM_COST_ROWMIN_EN
      if (m_count == 64) chk("cycle_lb", LB, model_lb());
`endif
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int val(input int mode, input int k);
    case (mode)
      0:       return k % 128;
      1:       return 7;
      2:       return 12;
      3:       return (k % 8 == 0) ? 1 : (k / 8 + 1);
      default: return 127;
    endcase
  endfunction

  task automatic stream(input int mode, input int n, input bit gaps);
    int  k = 0;
    int  c = 0;
    bit  v;
    CLR = 1'b0;
    while (k < n) begin
      v        = gaps ? ((c % 3) != 1 && (c % 7) != 5) : 1'b1;
      IN_VALID = v;
      IN_DATA  = 7'(val(mode, k));
      tick();
      if (v) k++;
      c++;
    end
    IN_VALID = 1'b0;
  endtask

  task automatic sweep(input int mode);
    for (int a = 0; a < 64; a++) begin
      W = 3'(a / 8);
      J = 3'(a % 8);
      tick();
      chk("sweep_cost", Cost, val(mode, a));
    end
  endtask

  task automatic restart();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; CLR = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; W = '0; J = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_cost", Cost, 0);
    chk("reset_count", COUNT, 0);
    chk("reset_loaded", LOADED, 0);
    RST_N = 1'b1;
    #1;
    chk("ready_after_reset", IN_READY, 1);

    // Gap-free stream of (w*8+j)%128.
    stream(0, 64, 1'b0);
    chk("nogap_loaded", LOADED, 1);
    chk("nogap_count", COUNT, 64);
    chk("nogap_ready_low", IN_READY, 0);
    W = 3'd5; J = 3'd3;
    tick();
    chk("nogap_cost_5_3", Cost, 43);
    IN_VALID = 1'b1; IN_DATA = 7'd1;
    repeat (3) tick();
    IN_VALID = 1'b0;
    chk("full_ignores_count", COUNT, 64);
    chk("full_ignores_cost", Cost, 43);

    // Same matrix streamed with valid gaps.
    restart();
    chk("clr_count", COUNT, 0);
    chk("clr_loaded", LOADED, 0);
    stream(0, 64, 1'b1);
    chk("gap_loaded", LOADED, 1);
    chk("gap_ready_low", IN_READY, 0);
    sweep(0);

    // CLR wins over a valid beat at COUNT=30, then reload all 7s.
    restart();
    stream(1, 30, 1'b0);
    chk("restart_count30", COUNT, 30);
    CLR = 1'b1; IN_VALID = 1'b1; IN_DATA = 7'd0;
    tick();
    CLR = 1'b0; IN_VALID = 1'b0;
    chk("restart_count0", COUNT, 0);
    chk("restart_loaded0", LOADED, 0);
    stream(1, 64, 1'b0);
    sweep(1);

    // Read-during-write at (2,4): old 12 then new 99.
    restart();
    stream(2, 64, 1'b0);
    restart();
    stream(2, 20, 1'b0);
    W = 3'd2; J = 3'd4; IN_VALID = 1'b1; IN_DATA = 7'd99;
    tick();
    IN_VALID = 1'b0;
    chk("rdw_old", Cost, 12);
    tick();
    chk("rdw_new", Cost, 99);
    stream(2, 43, 1'b0);
    chk("rdw_loaded", LOADED, 1);

    // Asynchronous reset in the middle of a load.
    restart();
    W = 3'd1; J = 3'd1;
    stream(0, 40, 1'b0);
    chk("async_pre_count", COUNT, 40);
    chk("async_pre_cost", Cost, 9);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_cost", Cost, 0);
    chk("async_loaded", LOADED, 0);
    chk("async_count", COUNT, 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    #1;
    chk("async_ready", IN_READY, 1);
    W = 3'd7; J = 3'd7;
    tick();
    chk("async_mem_cleared", Cost, 0);

`ifdef JAM_COST_ROWMIN_EN
    restart();
    stream(3, 64, 1'b0);
    chk("lb_rows", LB, 8);
    restart();
    chk("lb_clr", LB, 0);
    stream(4, 64, 1'b0);
    chk("lb_all127", LB, 1016);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
